// File: rtl/wb_bridge_pkg.sv
// Shared types for the Wishbone submap timeout bridge.
//   state_t : bridge FSM states
//   rsp_t   : kind of response held for the upstream side
package wb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_t;

  localparam int TIMEOUT_CNT_W = 16;
  localparam int WD_W          = 16;

endpackage

// File: rtl/wb_watchdog_cnt.sv
// Watchdog for one outstanding transaction. Down-counter reloaded on clr_i
// and decremented while en_i is high; tc_o flags the cycle in which the
// allowed budget of TIMEOUT enabled cycles is used up.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : reload for a new transaction
//   en_i         : count this cycle (transaction in flight)
//   tc_o         : terminal count reached this cycle (qualified by en_i)
module wb_watchdog_cnt
  import wb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // Loaded with TIMEOUT-1 so the terminal count lands on the TIMEOUT-th
  // enabled cycle after the reload.
  localparam logic [WD_W-1:0] LOAD = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WD_W'(1);
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/wb_sub_timeout_bridge.sv
// Bridge between a register block's Wishbone submap port (s_*) and a
// pipelined Wishbone slave (m_*). One transaction in flight; the request is
// registered onto m_* and the response is registered back onto s_*. A
// watchdog turns a silent slave into an error response.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   s_cyc_i .. s_dat_i    upstream request
//   s_ack/err/rty_o       one-cycle upstream response
//   s_stall_o, s_dat_o    upstream stall, read data
//   m_cyc_o .. m_dat_o    downstream request (registered)
//   m_ack/err/rty_i       downstream response
//   m_stall_i, m_dat_i    downstream stall, read data
//   timeout_o             sticky timeout flag
//   timeout_cnt_o         saturating timeout count
//   timeout_clr_i         clears timeout_o and timeout_cnt_o
//
// state | meaning
// IDLE  | ready for an upstream request
// ISSUE | strobe presented downstream, waiting for it to be accepted
// WAIT  | request accepted, waiting for ack/err/rty
// RESP  | one-cycle response driven upstream
module wb_sub_timeout_bridge
  import wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s_cyc_i,
  input  logic                     s_stb_i,
  input  logic [ADDR_WIDTH-1:0]    s_adr_i,
  input  logic [3:0]               s_sel_i,
  input  logic                     s_we_i,
  input  logic [31:0]              s_dat_i,
  output logic                     s_ack_o,
  output logic                     s_err_o,
  output logic                     s_rty_o,
  output logic                     s_stall_o,
  output logic [31:0]              s_dat_o,
  output logic                     m_cyc_o,
  output logic                     m_stb_o,
  output logic [ADDR_WIDTH-1:0]    m_adr_o,
  output logic [3:0]               m_sel_o,
  output logic                     m_we_o,
  output logic [31:0]              m_dat_o,
  input  logic                     m_ack_i,
  input  logic                     m_err_i,
  input  logic                     m_rty_i,
  input  logic                     m_stall_i,
  input  logic [31:0]              m_dat_i,
  output logic                     timeout_o,
  output logic [TIMEOUT_CNT_W-1:0] timeout_cnt_o,
  input  logic                     timeout_clr_i
);

  state_t state_q, state_d;
  rsp_t   rsp_q, rsp_d;
  logic   busy, rsp_in, wd_tc;
  logic   cap_req, rsp_take, to_fire;

  assign busy   = (state_q == ISSUE) || (state_q == WAIT);
  assign rsp_in = m_ack_i | m_err_i | m_rty_i;

  wb_watchdog_cnt #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cap_req),
    .en_i  (busy),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rsp_q   <= RSP_ACK;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  // Priority inside a transaction: upstream abort, then a slave response
  // (so a response on the watchdog's last cycle still wins), then timeout.
  // Responses are accepted in ISSUE as well, for slaves that answer early.
  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    cap_req  = 1'b0;
    rsp_take = 1'b0;
    to_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          cap_req = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (!s_cyc_i) begin
          state_d = IDLE;
        end else if (rsp_in) begin
          rsp_take = 1'b1;
          state_d  = RESP;
          if (m_err_i)      rsp_d = RSP_ERR;
          else if (m_rty_i) rsp_d = RSP_RTY;
          else              rsp_d = RSP_ACK;
        end else if (wd_tc) begin
          to_fire = 1'b1;
          rsp_d   = RSP_ERR;
          state_d = RESP;
        end else if ((state_q == ISSUE) && !m_stall_i) begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_adr_o       <= '0;
      m_sel_o       <= '0;
      m_we_o        <= 1'b0;
      m_dat_o       <= '0;
      s_dat_o       <= '0;
      timeout_o     <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      if (cap_req) begin
        m_adr_o <= s_adr_i;
        m_sel_o <= s_sel_i;
        m_we_o  <= s_we_i;
        m_dat_o <= s_dat_i;
      end
      if (rsp_take && !m_we_o) begin
        s_dat_o <= m_dat_i;
      end
      // A timeout in the same cycle as a clear survives as a fresh count of 1.
      if (to_fire) begin
        timeout_o <= 1'b1;
        if (timeout_clr_i)
          timeout_cnt_o <= TIMEOUT_CNT_W'(1);
        else if (timeout_cnt_o != '1)
          timeout_cnt_o <= timeout_cnt_o + TIMEOUT_CNT_W'(1);
      end else if (timeout_clr_i) begin
        timeout_o     <= 1'b0;
        timeout_cnt_o <= '0;
      end
    end
  end

  assign m_cyc_o   = busy;
  assign m_stb_o   = (state_q == ISSUE);
  assign s_stall_o = (state_q != IDLE);
  assign s_ack_o   = (state_q == RESP) && (rsp_q == RSP_ACK);
  assign s_err_o   = (state_q == RESP) && (rsp_q == RSP_ERR);
  assign s_rty_o   = (state_q == RESP) && (rsp_q == RSP_RTY);

endmodule

// File: tb/tb_wb_sub_timeout_bridge.sv
module tb_wb_sub_timeout_bridge;
  localparam int AW = 4;
  localparam int TO = 8;

  localparam logic [2:0] E_ACK = 3'b001;  // {err, rty, ack}
  localparam logic [2:0] E_RTY = 3'b010;
  localparam logic [2:0] E_ERR = 3'b100;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [AW-1:0] s_adr_i = '0;
  logic [3:0]    s_sel_i = '0;
  logic [31:0]   s_dat_i = '0;
  logic          s_ack_o, s_err_o, s_rty_o, s_stall_o;
  logic [31:0]   s_dat_o;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [AW-1:0] m_adr_o;
  logic [3:0]    m_sel_o;
  logic [31:0]   m_dat_o;
  logic          m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0, m_stall_i = 1'b0;
  logic [31:0]   m_dat_i = '0;
  logic          timeout_o;
  logic [15:0]   timeout_cnt_o;
  logic          timeout_clr_i = 1'b0;

  wb_sub_timeout_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_adr_i(s_adr_i), .s_sel_i(s_sel_i),
    .s_we_i(s_we_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .s_stall_o(s_stall_o), .s_dat_o(s_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_adr_o(m_adr_o), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .m_stall_i(m_stall_i), .m_dat_i(m_dat_i),
    .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o),
    .timeout_clr_i(timeout_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {K_ACK, K_ERR, K_RTY, K_ERRACK, K_NONE} kind_t;

  typedef struct {
    bit          we;
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          stall;     // cycles the slave stalls the strobe
    int          delay;     // extra cycles after acceptance before responding
    kind_t       kind;
    bit          early;     // respond in the first strobe cycle, while stalling
    logic [31:0] rdat;
    logic [2:0]  exp_rsp;
    int          exp_lat;   // cycle of the upstream response, request = cycle 0
    int          exp_stb;   // cycles with m_stb_o high
    logic [31:0] exp_sdat;
  } vec_t;

  typedef struct {
    logic [2:0]  rsp;
    int          lat;
    logic [31:0] sdat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_to = 1'b0;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit we, input logic [3:0] adr, input logic [3:0] sel,
                              input logic [31:0] wdat, input int stall, input int delay,
                              input kind_t kind, input bit early, input logic [31:0] rdat,
                              input logic [2:0] exp_rsp, input int exp_lat, input int exp_stb,
                              input logic [31:0] exp_sdat);
    vec_t v;
    v.we = we; v.adr = adr; v.sel = sel; v.wdat = wdat; v.stall = stall; v.delay = delay;
    v.kind = kind; v.early = early; v.rdat = rdat; v.exp_rsp = exp_rsp;
    v.exp_lat = exp_lat; v.exp_stb = exp_stb; v.exp_sdat = exp_sdat;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   stb_n = 0, cyc_n = 0, acc_k = -1, lat = -1, stall_left = v.stall;
    bit   seen_stb = 0;
    e.rsp = v.exp_rsp; e.lat = v.exp_lat; e.sdat = v.exp_sdat;
    sb_q.push_back(e);
    @(negedge clk_i);
    s_cyc_i = 1; s_stb_i = 1; s_we_i = v.we; s_adr_i = v.adr; s_sel_i = v.sel;
    s_dat_i = v.wdat; m_dat_i = v.rdat;
    chk("req_stall", 32'(s_stall_o), 32'(0));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      s_stb_i = 0; m_stall_i = 0; m_ack_i = 0; m_err_i = 0; m_rty_i = 0;
      if (s_ack_o | s_err_o | s_rty_o) begin
        lat = k;
        break;
      end
      if (m_cyc_o) cyc_n++;
      if (m_stb_o) begin
        stb_n++;
        if (!seen_stb) begin
          seen_stb = 1;
          chk("m_adr", 32'(m_adr_o), 32'(v.adr));
          chk("m_sel", 32'(m_sel_o), 32'(v.sel));
          chk("m_we", 32'(m_we_o), 32'(v.we));
          chk("m_dat", m_dat_o, v.wdat);
        end
        if (stall_left > 0) begin
          m_stall_i = 1;
          stall_left--;
        end else if (acc_k < 0) begin
          acc_k = k;
        end
      end
      if (v.kind != K_NONE &&
          ((v.early && k == 1) || (!v.early && acc_k >= 0 && k == acc_k + 1 + v.delay))) begin
        case (v.kind)
          K_ACK:    m_ack_i = 1;
          K_ERR:    m_err_i = 1;
          K_RTY:    m_rty_i = 1;
          K_ERRACK: begin m_err_i = 1; m_ack_i = 1; end
          default:  ;
        endcase
      end
    end
    m_stall_i = 0; m_ack_i = 0; m_err_i = 0; m_rty_i = 0;
    e = sb_q.pop_front();
    chk("rsp_kind", 32'({s_err_o, s_rty_o, s_ack_o}), 32'(e.rsp));
    chk("rsp_lat", 32'(lat), 32'(e.lat));
    chk("s_dat", s_dat_o, e.sdat);
    chk("stb_cycles", 32'(stb_n), 32'(v.exp_stb));
    chk("cyc_cycles", 32'(cyc_n), 32'(v.exp_lat - 1));
    if (v.kind == K_NONE) begin
      exp_to = 1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    chk("timeout_flag", 32'(timeout_o), 32'(exp_to));
    chk("timeout_cnt", 32'(timeout_cnt_o), 32'(exp_cnt));
    @(negedge clk_i);
    s_cyc_i = 0;
    chk("pulse_one", 32'({s_err_o, s_rty_o, s_ack_o, s_stall_o, m_cyc_o}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    //              we adr   sel   wdat          st dl kind      er rdat          exp    lat stb sdat
    vecs[0] = mk(1, 4'h3, 4'hF, 32'hDEADBEEF, 0, 0, K_ACK,    0, 32'hCAFEF00D, E_ACK, 3, 1, 32'h0);
    vecs[1] = mk(0, 4'h1, 4'hF, 32'h0,        4, 0, K_ACK,    0, 32'h12345678, E_ACK, 7, 5, 32'h12345678);
    vecs[2] = mk(0, 4'h2, 4'h3, 32'h0,        0, 1, K_ERRACK, 0, 32'hAAAA5555, E_ERR, 4, 1, 32'hAAAA5555);
    vecs[3] = mk(1, 4'h5, 4'hC, 32'h0BADF00D, 1, 0, K_RTY,    0, 32'hCAFEF00D, E_RTY, 4, 2, 32'hAAAA5555);
    vecs[4] = mk(0, 4'h7, 4'hF, 32'h0,        0, 0, K_NONE,   0, 32'h11111111, E_ERR, 9, 1, 32'hAAAA5555);
    vecs[5] = mk(0, 4'h8, 4'h1, 32'h0,       20, 0, K_NONE,   0, 32'h22222222, E_ERR, 9, 8, 32'hAAAA5555);
    vecs[6] = mk(1, 4'hE, 4'h2, 32'h5A5A5A5A, 3, 0, K_NONE,   0, 32'h33333333, E_ERR, 9, 4, 32'hAAAA5555);
    vecs[7] = mk(0, 4'hF, 4'hF, 32'h0,        0, 0, K_NONE,   0, 32'h44444444, E_ERR, 9, 1, 32'hAAAA5555);
    vecs[8] = mk(0, 4'h6, 4'hF, 32'h0,        0, 6, K_ACK,    0, 32'h600DCAFE, E_ACK, 9, 1, 32'h600DCAFE);
    vecs[9] = mk(0, 4'h4, 4'hF, 32'h0,        2, 0, K_ACK,    1, 32'h0E0E0E0E, E_ACK, 2, 1, 32'h0E0E0E0E);

    #2 rst_i = 1;
    #2;
    chk("reset_ctl", 32'({s_ack_o, s_err_o, s_rty_o, s_stall_o, m_cyc_o, m_stb_o, m_we_o, timeout_o}), 32'(0));
    chk("reset_sdat", s_dat_o, 32'h0);
    chk("reset_mreq", m_dat_o | 32'(m_adr_o) | 32'(m_sel_o), 32'h0);
    chk("reset_cnt", 32'(timeout_cnt_o), 32'(0));
    repeat (3) @(negedge clk_i);
    rst_i = 0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Clear after four timeouts.
    timeout_clr_i = 1;
    @(negedge clk_i);
    timeout_clr_i = 0;
    exp_cnt = 0; exp_to = 0;
    chk("clr_flag", 32'(timeout_o), 32'(exp_to));
    chk("clr_cnt", 32'(timeout_cnt_o), 32'(exp_cnt));

    // Clear held across a timeout: the timeout wins with a count of 1.
    timeout_clr_i = 1;
    run_txn(mk(0, 4'h7, 4'hF, 32'h0, 0, 0, K_NONE, 0, 32'h55555555, E_ERR, 9, 1, 32'h0E0E0E0E));
    timeout_clr_i = 0;
    exp_cnt = 0; exp_to = 0;
    chk("clr_after_hold", 32'(timeout_cnt_o), 32'(exp_cnt));

    // Upstream abort in WAIT, slave acks two cycles later.
    @(negedge clk_i);
    s_cyc_i = 1; s_stb_i = 1; s_we_i = 0; s_adr_i = 4'h9; s_sel_i = 4'hF; m_dat_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    s_stb_i = 0;
    chk("abort_issue_stb", 32'(m_stb_o), 32'(1));
    @(negedge clk_i);
    chk("abort_wait_cyc", 32'({m_cyc_o, m_stb_o}), 32'(2));
    s_cyc_i = 0;
    @(negedge clk_i);
    chk("abort_mcyc", 32'({m_cyc_o, m_stb_o}), 32'(0));
    @(negedge clk_i);
    m_ack_i = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      seen |= s_ack_o | s_err_o | s_rty_o | m_cyc_o;
      @(negedge clk_i);
      m_ack_i = 0;
    end
    chk("abort_no_rsp", 32'(seen), 32'(0));
    chk("abort_sdat", s_dat_o, 32'h0E0E0E0E);
    chk("abort_cnt", 32'(timeout_cnt_o), 32'(exp_cnt));
    run_txn(mk(1, 4'hA, 4'h1, 32'h00000055, 0, 2, K_ACK, 0, 32'h77777777, E_ACK, 5, 1, 32'h0E0E0E0E));

    // One timeout so the counter is nonzero, then async reset mid-WAIT.
    run_txn(mk(0, 4'hB, 4'hF, 32'h0, 0, 0, K_NONE, 0, 32'h66666666, E_ERR, 9, 1, 32'h0E0E0E0E));
    @(negedge clk_i);
    s_cyc_i = 1; s_stb_i = 1; s_we_i = 0; s_adr_i = 4'hC; m_dat_i = 32'h99999999;
    @(negedge clk_i);
    s_stb_i = 0;
    @(negedge clk_i);
    chk("rst_pre_wait", 32'({m_cyc_o, m_stb_o}), 32'(2));
    #2 rst_i = 1;
    #1;
    chk("rst_async_m", 32'({m_cyc_o, m_stb_o, s_stall_o}), 32'(0));
    chk("rst_async_cnt", 32'({timeout_o, timeout_cnt_o}), 32'(0));
    @(negedge clk_i);
    rst_i = 0; s_cyc_i = 0;
    exp_cnt = 0; exp_to = 0;
    run_txn(mk(0, 4'h2, 4'hF, 32'h0, 0, 0, K_ACK, 0, 32'h76543210, E_ACK, 3, 1, 32'h76543210));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sub_timeout_bridge.md
Name: wb_sub_timeout_bridge

Overview:
Sits directly downstream of a generated register block's Wishbone submap port and forwards each transaction to the real pipelined Wishbone slave behind it. Single outstanding transaction; registers the request and the response. Watchdog aborts a transaction with an error if the slave never answers, so a dead slave cannot hang the bus.

Parameters:
ADDR_WIDTH, 4, width of s_adr_i / m_adr_o (word address).
TIMEOUT, 255, cycles allowed from first m_stb_o assertion to response before abort; legal range 2..65535.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
s_cyc_i  in  1  upstream cycle
s_stb_i  in  1  upstream strobe
s_adr_i  in  ADDR_WIDTH  upstream address
s_sel_i  in  4  upstream byte select
s_we_i  in  1  upstream write enable
s_dat_i  in  32  upstream write data
s_ack_o  out  1  response: ok
s_err_o  out  1  response: error (slave err or timeout)
s_rty_o  out  1  response: retry (slave rty)
s_stall_o  out  1  upstream stall
s_dat_o  out  32  read data
m_cyc_o  out  1  downstream cycle
m_stb_o  out  1  downstream strobe
m_adr_o  out  ADDR_WIDTH  downstream address
m_sel_o  out  4  downstream byte select
m_we_o  out  1  downstream write enable
m_dat_o  out  32  downstream write data
m_ack_i  in  1  downstream ack
m_err_i  in  1  downstream err
m_rty_i  in  1  downstream rty
m_stall_i  in  1  downstream stall
m_dat_i  in  32  downstream read data
timeout_o  out  1  sticky: a timeout occurred
timeout_cnt_o  out  16  saturating count of timeouts
timeout_clr_i  in  1  clears timeout_o and timeout_cnt_o

Behaviour:
- Reset (rst_i high, async): state IDLE; all outputs 0 except s_stall_o=0; captured request regs, s_dat_o, timeout counter, timeout_o, timeout_cnt_o cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: s_stall_o=0. On s_cyc_i&s_stb_i: capture adr/sel/we/dat into m_*_o regs, load watchdog=0, go ISSUE.
- ISSUE: m_cyc_o=1, m_stb_o=1, s_stall_o=1. If !m_stall_i go WAIT. m_*_o stable until accepted.
- WAIT: m_cyc_o=1, m_stb_o=0, s_stall_o=1. On m_ack_i|m_err_i|m_rty_i: latch m_dat_i into s_dat_o (reads only; writes leave s_dat_o unchanged), latch response kind, drop m_cyc_o next cycle, go RESP.
- Response accepted in ISSUE too: if a response input is high in ISSUE, treat as WAIT response (tolerant of non-compliant slaves).
- RESP: exactly one cycle of s_ack_o / s_err_o / s_rty_o (exactly one high); s_stall_o=1; next state IDLE. Priority if several response inputs are high together: err > rty > ack.
- Latency with a zero-stall, next-cycle-ack slave: request sampled at cycle 0, m_stb_o cycle 1, m_ack_i cycle 2, s_ack_o cycle 3.
- Watchdog: increments each cycle in ISSUE/WAIT. When it equals TIMEOUT-1 with no response that cycle: drop m_cyc_o/m_stb_o, go RESP with s_err_o, set timeout_o, timeout_cnt_o+=1 (saturates at 16'hFFFF). Response and timeout in the same cycle: response wins, no timeout counted.
- Upstream abort: s_cyc_i low while in ISSUE/WAIT. Drop m_cyc_o/m_stb_o the next cycle, go IDLE, emit no s_* response, no timeout counted. Late m_ack_i after abort is ignored in IDLE.
- timeout_clr_i: synchronous. A timeout in the same cycle wins, giving timeout_o=1 and cnt=1.
- s_stb_i while stalled is ignored; upstream must hold the request per pipelined WB rules.

Decomposition:
- Package wb_bridge_pkg: state enum (IDLE, ISSUE, WAIT, RESP), response-kind enum (RSP_ACK, RSP_ERR, RSP_RTY), TIMEOUT_CNT_W=16.
- Sub-module wb_watchdog_cnt: clear/enable/terminal-count counter parameterised by TIMEOUT. Bridge FSM instantiates it once.

Test Plan:
- Write adr=3, dat=32'hDEADBEEF, sel=4'hF, slave no stall, ack next cycle -> m_dat_o=DEADBEEF, m_we_o=1, s_ack_o pulse at cycle 3, s_err_o=0.
- Read adr=1, slave stalls 4 cycles then acks with 32'h12345678 -> m_stb_o high 5 cycles, s_dat_o=12345678 with s_ack_o one cycle.
- TIMEOUT=8, slave never responds -> m_cyc_o drops after 8 cycles of m_cyc_o, s_err_o single pulse, timeout_o=1, timeout_cnt_o=1. Repeat 3 times -> cnt=4, then timeout_clr_i -> 0.
- Slave asserts m_err_i and m_ack_i together -> s_err_o=1, s_ack_o=0. m_rty_i alone -> s_rty_o=1.
- s_cyc_i dropped in WAIT, slave acks 2 cycles later -> m_cyc_o low next cycle, no s_* response, following transaction completes normally.
- rst_i asserted mid-WAIT (async, between clock edges) -> m_cyc_o/m_stb_o low immediately, state IDLE after release, timeout_cnt_o=0.
